lwe_ct_finalizer: RTL and testbench
===================================

Name: lwe_ct_finalizer

Overview:
Downstream stage of the MLA accumulator in the LWE encryptor. On `start`, it captures the four column accumulators and the sum accumulator, and reduces each to [0, Q) as a signed two's-complement value. It adds the encoded message bit to the sum element, then streams the five ciphertext words out over a valid/ready interface. It also pulses a clear so the accumulator can begin the next encryption.

Parameters:
- DATA_WIDTH, 12, width of one reduced ciphertext word; Q must be ≤ 2^DATA_WIDTH.
- ACC_WIDTH, 32, width of each accumulator input; interpreted as signed two's complement.
- Q, 3329, LWE modulus.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to capture the accumulators.
- msg_bit  in  1  plaintext bit, sampled together with start.
- acc_col1  in  ACC_WIDTH  column 1 accumulator.
- acc_col2  in  ACC_WIDTH  column 2 accumulator.
- acc_col3  in  ACC_WIDTH  column 3 accumulator.
- acc_col4  in  ACC_WIDTH  column 4 accumulator.
- acc_sum  in  ACC_WIDTH  sum accumulator.
- busy  out  1  high in every state except IDLE.
- acc_clr  out  1  one-cycle pulse clearing the upstream accumulators.
- ct_valid  out  1  ct_data is valid.
- ct_ready  in  1  downstream accepts the current word.
- ct_data  out  DATA_WIDTH  reduced word.
- ct_idx  out  3  element index 0..4 (0-3 = col1-col4, 4 = sum).
- ct_last  out  1  high when ct_idx == 4.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous and active-low. While rst_n is low, all of the following are 0: outputs busy, acc_clr, ct_valid, ct_data, ct_idx, ct_last; the FSM is in IDLE; all capture registers, the result buffer and the counters are cleared. Asserting rst_n mid-operation aborts the operation; there is no partial output afterwards.
- FSM states: IDLE, REDUCE, SEND.
- IDLE:
  - When start is high at edge E0, capture all five accumulators and msg_bit, then go to REDUCE.
  - acc_clr is high for exactly the cycle after E0.
- REDUCE:
  - One element is issued per cycle to the reducer, in index order 0..4, at edges E1..E5.
  - The reducer has a fixed latency of 2 cycles; results are written to the 5-entry result buffer at edges E3..E7.
  - Element 4 result = reduced(acc_sum) + msg_bit·floor(Q/2), minus Q if the sum is ≥ Q.
  - After the last write the FSM goes to SEND, so ct_valid rises at edge E8 with ct_idx = 0.
- SEND:
  - ct_valid stays high. ct_data, ct_idx and ct_last are held stable while ct_ready is low.
  - On ct_valid & ct_ready the index advances.
  - A handshake at ct_idx = 4 returns the FSM to IDLE, and ct_valid drops at that same edge.
  - ct_ready is ignored while ct_valid is low.
- start:
  - Ignored while busy: no capture and no acc_clr.
  - If start coincides with the final SEND handshake it is also ignored; busy is still high in that cycle.
- Reduction arithmetic:
  - Result = x mod Q using Euclidean (non-negative) semantics on the signed ACC_WIDTH input.
  - The most-negative input must be handled without overflow; use an ACC_WIDTH+1 intermediate.
  - The output is zero-extended from ceil(log2 Q) bits to DATA_WIDTH.

Decomposition:
- Package lwe_pkg holds:
  - Q and HALF_Q = Q/2 (integer division).
  - An enum for the FSM states (IDLE/REDUCE/SEND).
  - A typedef for the element index (3 bits) and the constant NUM_ELEMS = 5.
- Sub-module lwe_mod_reduce:
  - 2-stage pipelined signed reduction mod Q with an in_valid/out_valid sideband.
  - Reused later by the decryptor.

Test Plan:
- Q=3329, msg=0; acc_col1..4 = 5, -1, 3329, 6665; acc_sum = 100; start -> words 5, 3328, 0, 7, 100 at idx 0..4; ct_last only on idx 4; ct_valid first high 8 cycles after the start edge.
- msg=1, acc_sum=2000 -> idx 4 word = 335 (3664 - 3329); msg=1, acc_sum=0 -> 1664.
- acc_col1 = -2^31 -> idx 0 word = 988; acc_col2 = 2^31-1 -> 2340.
- ct_ready low for 3 cycles while ct_idx=2 -> ct_data/ct_idx stable, no word skipped or duplicated; total of exactly 5 handshakes.
- start pulsed during REDUCE and during SEND -> ignored, no extra acc_clr; exactly one acc_clr pulse per accepted start; a back-to-back start in the first cycle back in IDLE is accepted.
- rst_n low during SEND at idx 3 -> ct_valid/busy drop immediately (asynchronous); after release, a new start produces a full correct 5-word sequence.

Source files
------------

// File: rtl/lwe_pkg.sv
// Shared types and constants for the LWE encryptor datapath.
// Modulus, FSM states and ciphertext element indexing.
package lwe_pkg;

  localparam int Q      = 3329;
  localparam int HALF_Q = Q / 2;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    SEND
  } state_t;

  typedef logic [2:0] elem_idx_t;

  localparam elem_idx_t NUM_ELEMS = 3'd5;
  localparam elem_idx_t LAST_IDX  = 3'd4;

endpackage

// File: rtl/lwe_mod_reduce.sv
// Two-stage signed reduction x mod Q with Euclidean (non-negative) result.
// Stage 1 takes the truncated remainder, stage 2 folds negatives into [0, Q).
module lwe_mod_reduce #(
  parameter int ACC_WIDTH = 32,
  parameter int Q         = lwe_pkg::Q
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [ACC_WIDTH-1:0]   in_data,
  output logic                   out_valid,
  output logic [$clog2(Q)-1:0]   out_data
);

  localparam int RW = $clog2(Q);
  localparam int XW = ACC_WIDTH + 1;

  localparam logic signed [XW-1:0] Q_X = XW'(Q);
  localparam logic signed [RW:0]   Q_R = (RW + 1)'(Q);

  // One extra bit keeps the most-negative input from overflowing.
  logic signed [XW-1:0] x_ext;
  logic signed [RW:0]   rem_q;
  logic signed [RW:0]   rem_adj;
  logic                 v1_q;

  assign x_ext   = {in_data[ACC_WIDTH-1], in_data};
  assign rem_adj = rem_q + Q_R;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      v1_q      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      rem_q     <= (RW + 1)'(x_ext % Q_X);
      v1_q      <= in_valid;
      out_data  <= rem_q[RW] ? rem_adj[RW-1:0]
                             : rem_q[RW-1:0];
      out_valid <= v1_q;
    end
  end

endmodule

// File: rtl/lwe_ct_finalizer.sv
// Captures the MLA accumulators, reduces them mod Q, folds in the message
// bit and streams the five ciphertext words over valid/ready.
module lwe_ct_finalizer
  import lwe_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int Q          = lwe_pkg::Q
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  msg_bit,
  input  logic [ACC_WIDTH-1:0]  acc_col1,
  input  logic [ACC_WIDTH-1:0]  acc_col2,
  input  logic [ACC_WIDTH-1:0]  acc_col3,
  input  logic [ACC_WIDTH-1:0]  acc_col4,
  input  logic [ACC_WIDTH-1:0]  acc_sum,
  output logic                  busy,
  output logic                  acc_clr,
  output logic                  ct_valid,
  input  logic                  ct_ready,
  output logic [DATA_WIDTH-1:0] ct_data,
  output logic [2:0]            ct_idx,
  output logic                  ct_last
);

  localparam int RW = $clog2(Q);

  localparam logic [RW:0] Q_V  = (RW + 1)'(Q);
  localparam logic [RW:0] HQ_V = (RW + 1)'(Q / 2);

  state_t    state;
  state_t    state_nx;
  elem_idx_t iss_cnt;
  elem_idx_t wr_cnt;
  elem_idx_t snd_idx;

  logic [ACC_WIDTH-1:0] cap     [NUM_ELEMS];
  logic [RW-1:0]        res_buf [NUM_ELEMS];

  logic msg_q;
  logic acc_clr_q;
  logic start_ok;
  logic hs;

  logic                 red_in_valid;
  logic [ACC_WIDTH-1:0] red_in;
  logic                 red_out_valid;
  logic [RW-1:0]        red_out;

  logic          wr_en;
  logic [RW:0]   sum_w;
  logic [RW-1:0] wr_data;

  assign start_ok = (state == IDLE) && start;
  assign hs       = (state == SEND) && ct_ready;

  assign red_in_valid = (state == REDUCE)
                     && (iss_cnt < NUM_ELEMS);
  assign red_in       = red_in_valid ? cap[iss_cnt] : '0;

  lwe_mod_reduce #(
    .ACC_WIDTH (ACC_WIDTH),
    .Q         (Q)
  ) u_reduce (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (red_in_valid),
    .in_data   (red_in),
    .out_valid (red_out_valid),
    .out_data  (red_out)
  );

  // Sum element carries the encoded message: +floor(Q/2), wrapped once.
  assign sum_w = {1'b0, red_out} + (msg_q ? HQ_V : '0);

  always_comb begin
    wr_data = red_out;
    if (wr_cnt == LAST_IDX) begin
      wr_data = (sum_w >= Q_V) ? RW'(sum_w - Q_V)
                               : sum_w[RW-1:0];
    end
  end

  assign wr_en = red_out_valid
              && (state == REDUCE)
              && (wr_cnt < NUM_ELEMS);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = REDUCE;
      REDUCE:  if (wr_cnt == NUM_ELEMS) state_nx = SEND;
      SEND:    if (hs && snd_idx == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_clr_q <= 1'b0;
      msg_q     <= 1'b0;
      iss_cnt   <= '0;
      wr_cnt    <= '0;
      snd_idx   <= '0;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        cap[i]     <= '0;
        res_buf[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      acc_clr_q <= start_ok;
      if (start_ok) begin
        cap[0]  <= acc_col1;
        cap[1]  <= acc_col2;
        cap[2]  <= acc_col3;
        cap[3]  <= acc_col4;
        cap[4]  <= acc_sum;
        msg_q   <= msg_bit;
        iss_cnt <= '0;
        wr_cnt  <= '0;
        snd_idx <= '0;
      end
      if (red_in_valid) begin
        iss_cnt <= iss_cnt + 3'd1;
      end
      if (wr_en) begin
        res_buf[wr_cnt] <= wr_data;
        wr_cnt          <= wr_cnt + 3'd1;
      end
      if (hs) begin
        snd_idx <= (snd_idx == LAST_IDX) ? '0
                                         : snd_idx + 3'd1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign acc_clr  = acc_clr_q;
  assign ct_valid = (state == SEND);
  assign ct_idx   = ct_valid ? snd_idx : '0;
  assign ct_last  = ct_valid && (snd_idx == LAST_IDX);
  assign ct_data  = ct_valid ? DATA_WIDTH'(res_buf[snd_idx])
                             : '0;

endmodule

// File: tb/tb_lwe_ct_finalizer.sv
// Directed bench for lwe_ct_finalizer: reduction corners, message fold,
// back-pressure, ignored starts and asynchronous abort.
module tb_lwe_ct_finalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        msg_bit = 1'b0;
  logic [31:0] acc_col1 = '0;
  logic [31:0] acc_col2 = '0;
  logic [31:0] acc_col3 = '0;
  logic [31:0] acc_col4 = '0;
  logic [31:0] acc_sum = '0;
  logic        busy;
  logic        acc_clr;
  logic        ct_valid;
  logic        ct_ready = 1'b1;
  logic [11:0] ct_data;
  logic [2:0]  ct_idx;
  logic        ct_last;

  int total = 0;
  int bad = 0;
  int clr_cnt = 0;
  int hs_cnt = 0;
  int exp_clr = 0;
  int hs_base = 0;

  lwe_ct_finalizer #(
    .DATA_WIDTH (12),
    .ACC_WIDTH  (32),
    .Q          (3329)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .msg_bit  (msg_bit),
    .acc_col1 (acc_col1),
    .acc_col2 (acc_col2),
    .acc_col3 (acc_col3),
    .acc_col4 (acc_col4),
    .acc_sum  (acc_sum),
    .busy     (busy),
    .acc_clr  (acc_clr),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_data  (ct_data),
    .ct_idx   (ct_idx),
    .ct_last  (ct_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (acc_clr) clr_cnt++;
    if (ct_valid && ct_ready) hs_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] c1,
                        input logic [31:0] c2,
                        input logic [31:0] c3,
                        input logic [31:0] c4,
                        input logic [31:0] s,
                        input logic        m);
    acc_col1 = c1;
    acc_col2 = c2;
    acc_col3 = c3;
    acc_col4 = c4;
    acc_sum  = s;
    msg_bit  = m;
    start    = 1'b1;
    hs_base  = hs_cnt;
    exp_clr++;
    step();
    start = 1'b0;
    acc_col1 = '0;
    acc_col2 = '0;
    acc_col3 = '0;
    acc_col4 = '0;
    acc_sum  = '0;
    msg_bit  = 1'b0;
    chk("clr_pulse", 32'(acc_clr), 1);
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_valid(input bit poke);
    int c = 0;
    while (!ct_valid && c < 20) begin
      if (poke && c == 3) start = 1'b1;
      step();
      start = 1'b0;
      c++;
    end
    chk("latency", c, 8);
  endtask

  task automatic recv(input int ew [5],
                      input int stall_at,
                      input bit poke);
    for (int i = 0; i < 5; i++) begin
      if (i == stall_at) begin
        ct_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          chk("stall_idx", 32'(ct_idx), i);
          chk("stall_data", 32'(ct_data), ew[i]);
        end
        ct_ready = 1'b1;
      end
      chk("valid", 32'(ct_valid), 1);
      chk("idx", 32'(ct_idx), i);
      chk("data", 32'(ct_data), ew[i]);
      chk("last", 32'(ct_last), (i == 4) ? 1 : 0);
      if (poke && (i == 1 || i == 4)) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("valid_drop", 32'(ct_valid), 0);
    chk("idle", 32'(busy), 0);
    chk("no_clr", 32'(acc_clr), 0);
    chk("hs_total", hs_cnt - hs_base, 5);
    chk("clr_count", clr_cnt, exp_clr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa [5] = '{5, 3328, 0, 7, 100};
    int wb [5] = '{988, 2340, 0, 1, 335};
    int wc [5] = '{3328, 0, 3328, 13, 1664};
    int wd [5] = '{1, 2, 3, 4, 1663};
    int we [5] = '{7, 8, 9, 10, 11};

    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr", 32'(acc_clr), 0);
    chk("rst_valid", 32'(ct_valid), 0);
    chk("rst_data", 32'(ct_data), 0);
    chk("rst_idx", 32'(ct_idx), 0);
    chk("rst_last", 32'(ct_last), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    launch(32'd5, 32'hFFFF_FFFF, 32'd3329, 32'd6665,
           32'd100, 1'b0);
    wait_valid(1'b0);
    recv(wa, -1, 1'b0);
    step();

    launch(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1,
           32'd2000, 1'b1);
    wait_valid(1'b0);
    recv(wb, 2, 1'b0);
    step();

    launch(32'd3328, -32'sd3329, -32'sd3330, 32'd10000,
           32'd0, 1'b1);
    wait_valid(1'b1);
    recv(wc, -1, 1'b1);

    launch(32'd1, 32'd2, 32'd3, 32'd4,
           32'hFFFF_FFFF, 1'b1);
    wait_valid(1'b0);
    recv(wd, -1, 1'b0);
    step();

    launch(32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 1'b0);
    wait_valid(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pre_abort_data", 32'(ct_data), we[i]);
      step();
    end
    chk("abort_idx", 32'(ct_idx), 3);
    ct_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(ct_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_idx0", 32'(ct_idx), 0);
    step();
    step();
    rst_n = 1'b1;
    ct_ready = 1'b1;
    step();
    chk("post_abort_idle", 32'(busy), 0);

    launch(32'd5, 32'hFFFF_FFFF, 32'd3329, 32'd6665,
           32'd100, 1'b0);
    wait_valid(1'b0);
    recv(wa, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
